// File: rtl/cpu_mem_resp_pkg.sv
// Purpose : shared types and defaults for the fixed-latency CPU memory responder.
// Latency : n/a (types and constants only).
// Backpressure: n/a.
package cpu_mem_resp_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } state_e;

    typedef enum logic {
        PORT_I = 1'b0,
        PORT_D = 1'b1
    } port_e;

    localparam int DEF_DEPTH_WORDS = 1024;
    localparam int DEF_LATENCY     = 2;

    // Wide enough for the largest counter load (LATENCY-2 with LATENCY up to 15).
    localparam int CNT_W = 4;

endpackage

// File: rtl/cpu_mem_resp_array.sv
// Purpose : DEPTH_WORDS x 32 backing store, one synchronous read port, one byte-enabled write port.
// Latency : read data appears the cycle after rd_en; writes land on the clock edge.
// Backpressure: none, both ports accept every cycle.
//
// Ports: clk; rd_en/rd_idx -> rd_data (registered);
//        wr_en/wr_idx/wr_be/wr_data (wr_be[i] covers wr_data[8i+7:8i]).
// Contents are deliberately not reset.
module cpu_mem_resp_array #(
    parameter int DEPTH_WORDS = 1024,
    parameter int IDX_W       = 10
) (
    input  logic             clk,
    input  logic             rd_en,
    input  logic [IDX_W-1:0] rd_idx,
    output logic [31:0]      rd_data,
    input  logic             wr_en,
    input  logic [IDX_W-1:0] wr_idx,
    input  logic [3:0]       wr_be,
    input  logic [31:0]      wr_data
);

    logic [31:0] mem [DEPTH_WORDS];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            for (int b = 0; b < 4; b++) begin
                if (wr_be[b]) begin
                    mem[wr_idx][8*b +: 8] <= wr_data[8*b +: 8];
                end
            end
        end
        if (rd_en) begin
            rd_data <= mem[rd_idx];
        end
    end

endmodule

// File: rtl/cpu_mem_responder.sv
// Purpose : single-outstanding memory responder for a CPU imem/dmem port pair.
// Latency : resp pulses exactly LATENCY cycles after the acceptance cycle.
// Backpressure: requests are held by the CPU until resp; one in service, dmem wins over imem.
//
// Ports: clk, rst (async, active low);
//        imem_read/imem_address -> imem_rdata/imem_resp;
//        dmem_read/dmem_write/dmem_address/dmem_wdata/mem_byte_enable -> dmem_rdata/dmem_resp;
//        err (only with CPU_MEM_RESP_ERR_EN defined): pulses with resp on misaligned
//        or out-of-range addresses, which then neither write nor return data.
// Without CPU_MEM_RESP_ERR_EN the low address bits are ignored and the index wraps.
module cpu_mem_responder
    import cpu_mem_resp_pkg::*;
#(
    parameter int DEPTH_WORDS = DEF_DEPTH_WORDS,
    parameter int LATENCY     = DEF_LATENCY
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        imem_read,
    input  logic [31:0] imem_address,
    output logic [31:0] imem_rdata,
    output logic        imem_resp,
`ifdef CPU_MEM_RESP_ERR_EN
    output logic        err,
`endif
    input  logic        dmem_read,
    input  logic        dmem_write,
    input  logic [31:0] dmem_address,
    input  logic [31:0] dmem_wdata,
    input  logic [3:0]  mem_byte_enable,
    output logic [31:0] dmem_rdata,
    output logic        dmem_resp
);

    localparam int IDX_W    = $clog2(DEPTH_WORDS);
    localparam int LOAD_INT = (LATENCY > 1) ? LATENCY - 2 : 0;
    localparam logic [CNT_W-1:0] CNT_LOAD = LOAD_INT[CNT_W-1:0];

    state_e             state;
    logic [CNT_W-1:0]   cnt;
    port_e              lat_port;
    logic [IDX_W-1:0]   lat_idx;
    logic [31:0]        lat_wdata;
    logic [3:0]         lat_be;
    logic               lat_wr;
    logic               lat_err;
    logic [31:0]        imem_rdata_q;
    logic [31:0]        dmem_rdata_q;

    // Candidate request as seen this cycle (only meaningful in IDLE).
    logic               dmem_req;
    logic               accept;
    port_e              new_port;
    logic [31:0]        new_addr;
    logic [IDX_W-1:0]   new_idx;
    logic               new_wr;
    logic               new_err;

    assign dmem_req = dmem_read | dmem_write;
    assign accept   = (state == IDLE) && (dmem_req || imem_read);
    assign new_port = dmem_req ? PORT_D : PORT_I;
    assign new_addr = dmem_req ? dmem_address : imem_address;
    assign new_idx  = new_addr[IDX_W+1:2];
    // read+write together is served as a write
    assign new_wr   = dmem_req & dmem_write;

`ifdef CPU_MEM_RESP_ERR_EN
    assign new_err = (new_addr[1:0] != 2'b00) || (new_addr[31:IDX_W+2] != '0);
`else
    logic unused_addr_bits;
    assign new_err          = 1'b0;
    assign unused_addr_bits = ^{new_addr[1:0], new_addr[31:IDX_W+2]};
`endif

    // The array is accessed on the edge that enters RESP. With LATENCY=1 that
    // edge is the acceptance edge, before anything is latched, so the access
    // takes the live request in IDLE and the latched copy otherwise.
    logic               go_resp;
    logic [IDX_W-1:0]   sel_idx;
    logic [31:0]        sel_wdata;
    logic [3:0]         sel_be;
    logic               sel_wr;
    logic               sel_err;
    logic [31:0]        arr_rd_data;
    logic               arr_wr_en;
    logic               arr_rd_en;

    assign go_resp   = (accept && (LATENCY == 1)) || ((state == BUSY) && (cnt == '0));
    assign sel_idx   = (state == IDLE) ? new_idx         : lat_idx;
    assign sel_wdata = (state == IDLE) ? dmem_wdata      : lat_wdata;
    assign sel_be    = (state == IDLE) ? mem_byte_enable : lat_be;
    assign sel_wr    = (state == IDLE) ? new_wr          : lat_wr;
    assign sel_err   = (state == IDLE) ? new_err         : lat_err;
    assign arr_wr_en = go_resp && sel_wr && !sel_err;
    assign arr_rd_en = go_resp && !sel_wr;

    cpu_mem_resp_array #(
        .DEPTH_WORDS (DEPTH_WORDS),
        .IDX_W       (IDX_W)
    ) u_array (
        .clk     (clk),
        .rd_en   (arr_rd_en),
        .rd_idx  (sel_idx),
        .rd_data (arr_rd_data),
        .wr_en   (arr_wr_en),
        .wr_idx  (sel_idx),
        .wr_be   (sel_be),
        .wr_data (sel_wdata)
    );

    // Writes and erroring reads return zero.
    logic [31:0] resp_data;
    assign resp_data = (lat_wr || lat_err) ? 32'h0 : arr_rd_data;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state        <= IDLE;
            cnt          <= '0;
            lat_port     <= PORT_I;
            lat_idx      <= '0;
            lat_wdata    <= '0;
            lat_be       <= '0;
            lat_wr       <= 1'b0;
            lat_err      <= 1'b0;
            imem_rdata_q <= '0;
            dmem_rdata_q <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        lat_port  <= new_port;
                        lat_idx   <= new_idx;
                        lat_wdata <= dmem_wdata;
                        lat_be    <= mem_byte_enable;
                        lat_wr    <= new_wr;
                        lat_err   <= new_err;
                        if (LATENCY == 1) begin
                            state <= RESP;
                        end else begin
                            state <= BUSY;
                            cnt   <= CNT_LOAD;
                        end
                    end
                end
                BUSY: begin
                    if (cnt == '0) begin
                        state <= RESP;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                RESP: begin
                    state <= IDLE;
                    // Keep the served port's data visible after the pulse.
                    if (lat_port == PORT_D) begin
                        dmem_rdata_q <= resp_data;
                    end else begin
                        imem_rdata_q <= resp_data;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign imem_resp  = (state == RESP) && (lat_port == PORT_I);
    assign dmem_resp  = (state == RESP) && (lat_port == PORT_D);
    assign imem_rdata = imem_resp ? resp_data : imem_rdata_q;
    assign dmem_rdata = dmem_resp ? resp_data : dmem_rdata_q;
`ifdef CPU_MEM_RESP_ERR_EN
    assign err        = (state == RESP) && lat_err;
`endif

endmodule

// File: tb/tb_cpu_mem_responder.sv
module tb_cpu_mem_responder;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic [1:0]  imem_read;
    logic [31:0] imem_address [2];
    logic [31:0] imem_rdata   [2];
    logic [1:0]  imem_resp;
    logic [1:0]  dmem_read;
    logic [1:0]  dmem_write;
    logic [31:0] dmem_address [2];
    logic [31:0] dmem_wdata   [2];
    logic [3:0]  mem_be       [2];
    logic [31:0] dmem_rdata   [2];
    logic [1:0]  dmem_resp;
`ifdef CPU_MEM_RESP_ERR_EN
    logic [1:0]  err;
`endif

    int total = 0;
    int bad   = 0;

    cpu_mem_responder #(.DEPTH_WORDS(1024), .LATENCY(2)) u_dut_l2 (
        .clk             (clk),
        .rst             (rst),
        .imem_read       (imem_read[0]),
        .imem_address    (imem_address[0]),
        .imem_rdata      (imem_rdata[0]),
        .imem_resp       (imem_resp[0]),
`ifdef CPU_MEM_RESP_ERR_EN
        .err             (err[0]),
`endif
        .dmem_read       (dmem_read[0]),
        .dmem_write      (dmem_write[0]),
        .dmem_address    (dmem_address[0]),
        .dmem_wdata      (dmem_wdata[0]),
        .mem_byte_enable (mem_be[0]),
        .dmem_rdata      (dmem_rdata[0]),
        .dmem_resp       (dmem_resp[0])
    );

    cpu_mem_responder #(.DEPTH_WORDS(1024), .LATENCY(1)) u_dut_l1 (
        .clk             (clk),
        .rst             (rst),
        .imem_read       (imem_read[1]),
        .imem_address    (imem_address[1]),
        .imem_rdata      (imem_rdata[1]),
        .imem_resp       (imem_resp[1]),
`ifdef CPU_MEM_RESP_ERR_EN
        .err             (err[1]),
`endif
        .dmem_read       (dmem_read[1]),
        .dmem_write      (dmem_write[1]),
        .dmem_address    (dmem_address[1]),
        .dmem_wdata      (dmem_wdata[1]),
        .mem_byte_enable (mem_be[1]),
        .dmem_rdata      (dmem_rdata[1]),
        .dmem_resp       (dmem_resp[1])
    );

    // Drives one dmem request on instance d from an IDLE cycle, waits (bounded)
    // for its resp, drops the request and steps into the following IDLE cycle.
    // lat is the resp cycle counted from the acceptance cycle, -1 on timeout.
    task automatic dmem_txn(input int d, input logic rd, input logic wr,
                            input logic [31:0] addr, input logic [31:0] wdata,
                            input logic [3:0] be_i, output int lat,
                            output logic [31:0] rdat, output logic imem_seen,
                            output logic err_seen);
        dmem_read[d]    = rd;
        dmem_write[d]   = wr;
        dmem_address[d] = addr;
        dmem_wdata[d]   = wdata;
        mem_be[d]       = be_i;
        lat       = -1;
        rdat      = 32'h0;
        imem_seen = 1'b0;
        err_seen  = 1'b0;
        for (int c = 1; c <= 20; c++) begin
            @(negedge clk);
            if (imem_resp[d]) imem_seen = 1'b1;
            if (dmem_resp[d]) begin
                lat  = c;
                rdat = dmem_rdata[d];
`ifdef CPU_MEM_RESP_ERR_EN
                err_seen = err[d];
`endif
                break;
            end
        end
        dmem_read[d]  = 1'b0;
        dmem_write[d] = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b0;
        for (int d = 0; d < 2; d++) begin
            imem_read[d] = 1'b0; imem_address[d] = 32'h0;
            dmem_read[d] = 1'b0; dmem_write[d] = 1'b0;
            dmem_address[d] = 32'h0; dmem_wdata[d] = 32'h0; mem_be[d] = 4'h0;
        end
        repeat (2) @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            total++; if (imem_resp[d] !== 1'b0) begin bad++; $display("FAIL reset_imem_resp[%0d]: got %b want 0", d, imem_resp[d]); end
            total++; if (dmem_resp[d] !== 1'b0) begin bad++; $display("FAIL reset_dmem_resp[%0d]: got %b want 0", d, dmem_resp[d]); end
            total++; if (imem_rdata[d] !== 32'h0) begin bad++; $display("FAIL reset_imem_rdata[%0d]: got %h want 0", d, imem_rdata[d]); end
            total++; if (dmem_rdata[d] !== 32'h0) begin bad++; $display("FAIL reset_dmem_rdata[%0d]: got %h want 0", d, dmem_rdata[d]); end
`ifdef CPU_MEM_RESP_ERR_EN
            total++; if (err[d] !== 1'b0) begin bad++; $display("FAIL reset_err[%0d]: got %b want 0", d, err[d]); end
`endif
        end
        rst = 1'b1;
    endtask

    task automatic test_write_read();
        int lat; logic [31:0] rd; logic oi; logic e;
        dmem_txn(0, 1'b0, 1'b1, 32'h40, 32'hDEADBEEF, 4'hF, lat, rd, oi, e);
        total++; if (lat !== 2) begin bad++; $display("FAIL wr_latency: got %0d want 2", lat); end
        total++; if (rd !== 32'h0) begin bad++; $display("FAIL wr_rdata_zero: got %h want 0", rd); end
        total++; if (oi !== 1'b0) begin bad++; $display("FAIL wr_no_imem_resp: got %b want 0", oi); end
        dmem_txn(0, 1'b1, 1'b0, 32'h40, 32'h0, 4'h0, lat, rd, oi, e);
        total++; if (lat !== 2) begin bad++; $display("FAIL rd_latency: got %0d want 2", lat); end
        total++; if (rd !== 32'hDEADBEEF) begin bad++; $display("FAIL rd_data: got %h want deadbeef", rd); end
    endtask

    task automatic test_byte_enable();
        int lat; logic [31:0] rd; logic oi; logic e;
        dmem_txn(0, 1'b0, 1'b1, 32'h40, 32'h000000AA, 4'b0001, lat, rd, oi, e);
        dmem_txn(0, 1'b1, 1'b0, 32'h40, 32'h0, 4'h0, lat, rd, oi, e);
        total++; if (rd !== 32'hDEADBEAA) begin bad++; $display("FAIL be_0001: got %h want deadbeaa", rd); end
        dmem_txn(0, 1'b0, 1'b1, 32'h40, 32'h11223344, 4'b1010, lat, rd, oi, e);
        dmem_txn(0, 1'b1, 1'b0, 32'h40, 32'h0, 4'h0, lat, rd, oi, e);
        total++; if (rd !== 32'h11AD33AA) begin bad++; $display("FAIL be_1010: got %h want 11ad33aa", rd); end
        // read and write both high is a write
        dmem_txn(0, 1'b1, 1'b1, 32'h44, 32'h12345678, 4'hF, lat, rd, oi, e);
        total++; if (rd !== 32'h0) begin bad++; $display("FAIL rdwr_rdata_zero: got %h want 0", rd); end
        dmem_txn(0, 1'b1, 1'b0, 32'h44, 32'h0, 4'h0, lat, rd, oi, e);
        total++; if (rd !== 32'h12345678) begin bad++; $display("FAIL rdwr_is_write: got %h want 12345678", rd); end
    endtask

    task automatic test_priority();
        int lat; logic [31:0] rd; logic oi; logic e;
        int dd; int di; logic both;
        logic [31:0] d_dat; logic [31:0] i_dat; logic [31:0] i_hold; logic [31:0] d_hold;
        dmem_txn(0, 1'b0, 1'b1, 32'h80, 32'hCAFEF00D, 4'hF, lat, rd, oi, e);
        dd = -1; di = -1; both = 1'b0;
        d_dat = 32'h0; i_dat = 32'h0; i_hold = 32'hFFFFFFFF; d_hold = 32'hFFFFFFFF;
        dmem_read[0] = 1'b1; dmem_address[0] = 32'h40;
        imem_read[0] = 1'b1; imem_address[0] = 32'h80;
        for (int c = 1; c <= 8; c++) begin
            @(negedge clk);
            if (imem_resp[0] && dmem_resp[0]) both = 1'b1;
            if (dmem_resp[0] && dd < 0) begin
                dd = c; d_dat = dmem_rdata[0]; i_hold = imem_rdata[0];
                dmem_read[0] = 1'b0;
            end
            if (imem_resp[0] && di < 0) begin
                di = c; i_dat = imem_rdata[0]; d_hold = dmem_rdata[0];
                imem_read[0] = 1'b0;
            end
        end
        dmem_read[0] = 1'b0; imem_read[0] = 1'b0;
        total++; if (dd !== 2) begin bad++; $display("FAIL prio_dmem_cycle: got %0d want 2", dd); end
        total++; if (di !== 5) begin bad++; $display("FAIL prio_imem_cycle: got %0d want 5", di); end
        total++; if (both !== 1'b0) begin bad++; $display("FAIL prio_both_resp: got %b want 0", both); end
        total++; if (d_dat !== 32'h11AD33AA) begin bad++; $display("FAIL prio_dmem_data: got %h want 11ad33aa", d_dat); end
        total++; if (i_dat !== 32'hCAFEF00D) begin bad++; $display("FAIL prio_imem_data: got %h want cafef00d", i_dat); end
        total++; if (i_hold !== 32'h0) begin bad++; $display("FAIL prio_imem_hold: got %h want 0", i_hold); end
        total++; if (d_hold !== 32'h11AD33AA) begin bad++; $display("FAIL prio_dmem_hold: got %h want 11ad33aa", d_hold); end
    endtask

    task automatic test_busy_change();
        int lat; logic [31:0] rd;
        lat = -1; rd = 32'h0;
        dmem_read[0] = 1'b1; dmem_address[0] = 32'h40; mem_be[0] = 4'hF;
        @(negedge clk);
        // now in BUSY: change the address under the request in service
        dmem_address[0] = 32'h44; mem_be[0] = 4'h0;
        if (dmem_resp[0]) begin lat = 1; rd = dmem_rdata[0]; end
        for (int c = 2; c <= 10 && lat < 0; c++) begin
            @(negedge clk);
            if (dmem_resp[0]) begin lat = c; rd = dmem_rdata[0]; end
        end
        dmem_read[0] = 1'b0;
        @(negedge clk);
        total++; if (lat !== 2) begin bad++; $display("FAIL busy_chg_latency: got %0d want 2", lat); end
        total++; if (rd !== 32'h11AD33AA) begin bad++; $display("FAIL busy_chg_data: got %h want 11ad33aa", rd); end
    endtask

    task automatic test_reset_busy();
        int lat; logic [31:0] rd; logic oi; logic e; logic seen;
        dmem_txn(0, 1'b0, 1'b1, 32'h10, 32'h0BADF00D, 4'hF, lat, rd, oi, e);
        dmem_txn(0, 1'b1, 1'b0, 32'h40, 32'h0, 4'h0, lat, rd, oi, e);
        dmem_write[0] = 1'b1; dmem_address[0] = 32'h10;
        dmem_wdata[0] = 32'hFFFFFFFF; mem_be[0] = 4'hF;
        @(negedge clk);
        rst = 1'b0;
        #1;
        dmem_write[0] = 1'b0;
        seen = 1'b0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            if (dmem_resp[0]) seen = 1'b1;
        end
        total++; if (seen !== 1'b0) begin bad++; $display("FAIL rstbusy_no_resp: got %b want 0", seen); end
        total++; if (dmem_rdata[0] !== 32'h0) begin bad++; $display("FAIL rstbusy_dmem_rdata: got %h want 0", dmem_rdata[0]); end
        total++; if (imem_rdata[0] !== 32'h0) begin bad++; $display("FAIL rstbusy_imem_rdata: got %h want 0", imem_rdata[0]); end
        rst = 1'b1;
        dmem_txn(0, 1'b1, 1'b0, 32'h10, 32'h0, 4'h0, lat, rd, oi, e);
        total++; if (rd !== 32'h0BADF00D) begin bad++; $display("FAIL rstbusy_word_kept: got %h want 0badf00d", rd); end
    endtask

    task automatic test_lat1_stream();
        int lat; logic [31:0] rd; logic oi; logic e; int k; logic exp_resp;
        for (int w = 0; w < 4; w++) begin
            dmem_txn(1, 1'b0, 1'b1, 32'(w * 4), 32'h10000001 * 32'(w + 1), 4'hF, lat, rd, oi, e);
            total++; if (lat !== 1) begin bad++; $display("FAIL lat1_wr_latency[%0d]: got %0d want 1", w, lat); end
        end
        k = 0;
        imem_read[1] = 1'b1; imem_address[1] = 32'h0;
        for (int c = 1; c <= 8; c++) begin
            @(negedge clk);
            exp_resp = (c % 2) == 1;
            total++; if (imem_resp[1] !== exp_resp) begin bad++; $display("FAIL lat1_resp_c%0d: got %b want %b", c, imem_resp[1], exp_resp); end
            if (imem_resp[1]) begin
                total++; if (imem_rdata[1] !== 32'h10000001 * 32'(k + 1)) begin bad++; $display("FAIL lat1_data[%0d]: got %h want %h", k, imem_rdata[1], 32'h10000001 * 32'(k + 1)); end
                k++;
                imem_address[1] = 32'(k * 4);
                if (k == 4) imem_read[1] = 1'b0;
            end
        end
        imem_read[1] = 1'b0;
        @(negedge clk);
        total++; if (k !== 4) begin bad++; $display("FAIL lat1_count: got %0d want 4", k); end
    endtask

    task automatic test_err_wrap();
        int lat; logic [31:0] rd; logic oi; logic e;
        dmem_txn(0, 1'b0, 1'b1, 32'h0, 32'h55555555, 4'hF, lat, rd, oi, e);
        dmem_txn(0, 1'b0, 1'b1, 32'h1000, 32'h77777777, 4'hF, lat, rd, oi, e);
        total++; if (lat !== 2) begin bad++; $display("FAIL oor_wr_latency: got %0d want 2", lat); end
`ifdef CPU_MEM_RESP_ERR_EN
        total++; if (e !== 1'b1) begin bad++; $display("FAIL oor_wr_err: got %b want 1", e); end
        dmem_txn(0, 1'b1, 1'b0, 32'h0, 32'h0, 4'h0, lat, rd, oi, e);
        total++; if (rd !== 32'h55555555) begin bad++; $display("FAIL oor_word0_kept: got %h want 55555555", rd); end
        total++; if (e !== 1'b0) begin bad++; $display("FAIL aligned_no_err: got %b want 0", e); end
        dmem_txn(0, 1'b1, 1'b0, 32'h2, 32'h0, 4'h0, lat, rd, oi, e);
        total++; if (e !== 1'b1) begin bad++; $display("FAIL misalign_err: got %b want 1", e); end
        total++; if (rd !== 32'h0) begin bad++; $display("FAIL misalign_data: got %h want 0", rd); end
`else
        dmem_txn(0, 1'b1, 1'b0, 32'h0, 32'h0, 4'h0, lat, rd, oi, e);
        total++; if (rd !== 32'h77777777) begin bad++; $display("FAIL wrap_word0: got %h want 77777777", rd); end
        dmem_txn(0, 1'b1, 1'b0, 32'h2, 32'h0, 4'h0, lat, rd, oi, e);
        total++; if (rd !== 32'h77777777) begin bad++; $display("FAIL lowbits_ignored: got %h want 77777777", rd); end
`endif
    endtask

    initial begin
        test_reset();
        test_write_read();
        test_byte_enable();
        test_priority();
        test_busy_change();
        test_reset_busy();
        test_lat1_stream();
        test_err_wrap();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/cpu_mem_responder.md
CPU_MEM_RESPONDER -- requirements
Module: cpu_mem_responder

Interface
REQ-001 Parameter DEPTH_WORDS, default 1024, number of 32-bit words in backing store (power of two).
REQ-002 Parameter LATENCY, default 2, cycles from request acceptance to resp (legal 1..15).
REQ-003 clk  input  1  single clock; all state on rising edge.
REQ-004 rst  input  1  asynchronous, active-low reset.
REQ-005 imem_read  input  1  instruction read request, held until imem_resp.
REQ-006 imem_address  input  32  instruction byte address.
REQ-007 imem_rdata  output  32  instruction read data, valid when imem_resp=1.
REQ-008 imem_resp  output  1  one-cycle completion pulse for the imem port.
REQ-009 dmem_read  input  1  data read request, held until dmem_resp.
REQ-010 dmem_write  input  1  data write request, held until dmem_resp.
REQ-011 dmem_address  input  32  data byte address.
REQ-012 dmem_wdata  input  32  write data.
REQ-013 mem_byte_enable  input  4  per-byte write enable, bit i covers wdata[8i+7:8i].
REQ-014 dmem_rdata  output  32  data read data, valid when dmem_resp=1.
REQ-015 dmem_resp  output  1  one-cycle completion pulse for the dmem port.

Function
REQ-016 FSM states IDLE, BUSY, RESP; exactly one request in service at a time.
REQ-017 IDLE: any pending request accepted; dmem has fixed priority over imem; selected port, word index (address[31:2] mod DEPTH_WORDS), wdata and byte enables latched at acceptance.
REQ-018 Acceptance with LATENCY=1 goes IDLE->RESP; otherwise IDLE->BUSY with down-counter loaded to LATENCY-2, BUSY->RESP when counter=0.
REQ-019 resp of the served port SHALL be high in exactly the one cycle LATENCY cycles after the acceptance cycle; other port's resp stays 0.
REQ-020 Read data SHALL be registered and driven on the served port's rdata during RESP; rdata of the non-served port holds its previous value.
REQ-021 Write SHALL be committed at the edge entering RESP, using latched byte enables; disabled bytes unchanged; dmem_rdata is don't-care for writes and driven 0.
REQ-022 dmem_read and dmem_write both high: treated as write.
REQ-023 RESP->IDLE unconditionally; a request still asserted in the following IDLE cycle is a new request (re-serving an unchanged read or write is idempotent).
REQ-024 imem request waiting behind dmem remains pending and is accepted in the first IDLE cycle with no dmem request.
REQ-025 Input changes during BUSY SHALL NOT affect the request in service.
REQ-026 Back-to-back throughput: one completed request per LATENCY+1 cycles.

Reset
REQ-027 rst=0 asynchronously forces IDLE, counter 0, imem_resp=0, dmem_resp=0, imem_rdata=0, dmem_rdata=0.
REQ-028 Reset during BUSY abandons the request; no write committed; array contents not reset.

Configuration
REQ-029 Macro CPU_MEM_RESP_ERR_EN defined: adds output err (1 bit, reset 0), pulsed with resp when the latched address has address[1:0]!=0 or address[31:2]>=DEPTH_WORDS; an erroring write SHALL NOT modify the array; erroring read returns 0.
REQ-030 Macro undefined: no err port; low address bits ignored, index wraps modulo DEPTH_WORDS.

Structure
REQ-031 Package cpu_mem_resp_pkg holds state enum (IDLE/BUSY/RESP), port-select enum (PORT_I/PORT_D) and default parameter constants.
REQ-032 Sub-module cpu_mem_resp_array: DEPTH_WORDS x 32 storage, one synchronous read port, one byte-enabled write port.

Verification
REQ-033 LATENCY=2, write 0xDEADBEEF to 0x40 be=1111, then dmem read 0x40 -> dmem_resp in cycle 2 after each acceptance, rdata=0xDEADBEEF.
REQ-034 Word 0x40=0xDEADBEEF, write 0x000000AA be=0001 -> read returns 0xDEADBEAA.
REQ-035 imem read 0x80 and dmem read 0x40 asserted same cycle -> dmem_resp at cycle 2, imem_resp at cycle 5, never both high.
REQ-036 rst low during BUSY of write to 0x10 -> no resp, word 0x10 unchanged after reset release.
REQ-037 LATENCY=1, imem held high reading 0x0,0x4,... -> imem_resp every 2nd cycle, correct sequential data.
REQ-038 CPU_MEM_RESP_ERR_EN, DEPTH_WORDS=1024, write to 0x1000 -> err=1 with dmem_resp, word 0 unchanged; without macro, same write lands in word 0.
